mode_counter: RTL

Parametrised successor to the team's free-running overflow counter. Adds a runtime terminal value, clock-enable prescaling, synchronous load and four counting modes: wrap-up, wrap-down, one-shot and ping-pong. It drives 7-segment scan timing and animation sequencing. It emits a registered one-cycle terminal-count pulse for cascading into further counters.

---
 rtl/mode_counter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mode_counter.sv
// Prescaled up/down/one-shot/ping-pong counter with runtime terminal value,
// synchronous load and a registered one-cycle terminal-count pulse.
module mode_counter #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             dir_o,
  output logic             done_o
);

  localparam int unsigned     PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);
  localparam logic [1:0]      MODE_UP   = 2'b00;
  localparam logic [1:0]      MODE_DOWN = 2'b01;
  localparam logic [1:0]      MODE_ONE  = 2'b10;
  localparam logic [1:0]      MODE_PING = 2'b11;

  logic [PW-1:0]    ps_q, ps_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d, dir_d, done_d;
  logic             step;
  logic [WIDTH:0]   inc_x, max_x;

  // One extra bit keeps count+1 >= max honest when count sits at all-ones.
  assign inc_x = {1'b0, count_o} + (WIDTH+1)'(1);
  assign max_x = {1'b0, max_i};
  assign step  = en_i && (ps_q == PS_LAST);

  // Next-state: load beats step; mode-derived dir/done updates happen every cycle.
  always_comb begin
    ps_d    = ps_q;
    count_d = count_o;
    tc_d    = 1'b0;
    dir_d   = dir_o;
    done_d  = done_o;

    if (load_i) begin
      count_d = (load_val_i > max_i) ? max_i : load_val_i;
      ps_d    = '0;
      done_d  = 1'b0;
      dir_d   = (mode_i == MODE_DOWN);
    end else begin
      if (en_i) ps_d = step ? '0 : ps_q + PW'(1);

      case (mode_i)
        MODE_UP:   begin dir_d = 1'b0; done_d = 1'b0; end
        MODE_DOWN: begin dir_d = 1'b1; done_d = 1'b0; end
        MODE_ONE:  dir_d = 1'b0;
        MODE_PING: done_d = 1'b0;
      endcase

      if (step) begin
        case (mode_i)
          MODE_UP: begin
            if (count_o >= max_i) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = inc_x[WIDTH-1:0];
            end
          end
          MODE_DOWN: begin
            if (count_o == '0) begin
              count_d = max_i;
              tc_d    = 1'b1;
            end else if (count_o > max_i) begin
              count_d = max_i;
            end else begin
              count_d = count_o - WIDTH'(1);
            end
          end
          MODE_ONE: begin
            if (!done_o) begin
              if (inc_x >= max_x) begin
                count_d = max_i;
                done_d  = 1'b1;
                tc_d    = 1'b1;
              end else begin
                count_d = inc_x[WIDTH-1:0];
              end
            end
          end
          MODE_PING: begin
            if (max_i == '0) begin
              count_d = '0;
              dir_d   = 1'b0;
              tc_d    = 1'b1;
            end else if (!dir_o) begin
              if (inc_x >= max_x) begin
                count_d = max_i;
                dir_d   = 1'b1;
              end else begin
                count_d = inc_x[WIDTH-1:0];
              end
            end else begin
              // Guard against underflow if max_i moved under a descending count.
              if (count_o <= WIDTH'(1)) begin
                count_d = '0;
                dir_d   = 1'b0;
                tc_d    = 1'b1;
              end else begin
                count_d = count_o - WIDTH'(1);
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps_q    <= '0;
      count_o <= '0;
      tc_o    <= 1'b0;
      dir_o   <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      count_o <= count_d;
      tc_o    <= tc_d;
      dir_o   <= dir_d;
      done_o  <= done_d;
    end
  end

endmodule
